receiver: RTL and testbench
===========================

# receiver

UART serial receiver: the downstream counterpart of the transmitter. It recovers 8-bit frames (start bit, 8 data bits LSB first, stop bit) from the asynchronous `rx` line using an oversampling tick. It sits between the board pin and the consumer logic, presenting each byte with a one-cycle valid pulse. The shared baud generator provides `os_tick` at OVERSAMPLE × baud rate.

## Interface
- `OVERSAMPLE`, default 16: os_tick pulses per bit period. Must be even and ≥ 4.
- `clk` input 1: system clock; all logic is on posedge.
- `rst` input 1: asynchronous, active-low reset.
- `os_tick` input 1: one-`clk`-wide pulse at OVERSAMPLE × baud.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `data_out` output 8: last received byte; holds until the next frame completes.
- `valid` output 1: one-cycle pulse when a frame is received with a good stop bit.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `parity_err` output 1: parity mismatch flag (see Configuration).
- `busy` output 1: high from start-bit detection until the frame ends.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rx_s` and its previous-cycle copy.
- Tick counter: width $clog2(OVERSAMPLE). It advances only on `os_tick` and is cleared on every state change.
- Bit index: 3 bits, covering data bits 0..7.
- IDLE:
  - `busy` is 0.
  - A falling edge on `rx_s` (previous 1, current 0) moves to START and clears the counter.
  - A line held low does not re-trigger.
- START:
  - On the os_tick that brings the count to OVERSAMPLE/2 (mid start bit), sample `rx_s`.
  - Sample 0: go to DATA, bit index = 0.
  - Sample 1: false start; return to IDLE with no output pulses.
- DATA:
  - Every OVERSAMPLE ticks (the mid-bit of each data bit), shift `rx_s` into shift_reg[bit index], then increment the bit index.
  - After the bit-7 sample, go to PARITY if it is compiled in, otherwise STOP.
- PARITY (macro only): sample one bit after OVERSAMPLE ticks, then go to STOP.
- STOP, on the sample after OVERSAMPLE ticks:
  - `data_out` ← shift_reg.
  - Sample 1: pulse `valid`.
  - Sample 0: pulse `frame_err`; `valid` stays 0.
  - Either way, return to IDLE.
- Break or stuck-low line after a framing error: the next frame waits for `rx_s` to go high and then see a fresh falling edge.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data_out`=8'h00, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state=IDLE, counters=0, shift_reg=0.
- Asserting reset mid-frame aborts immediately, with no pulse. After release, the block waits for a fresh falling edge.
- `rx` to `rx_s` latency is 2 cycles.
- START entry: the cycle after the falling edge appears on `rx_s`. `busy` is registered high in that same cycle.
- Output pulses (`valid` / `frame_err` / `parity_err`) and the `data_out` update: registered, visible the cycle after the stop-sample os_tick.
- `busy` falls in that same cycle.
- Sampling point: bit n is sampled OVERSAMPLE/2 + (n+1)·OVERSAMPLE ticks after start detection (n = 0..7). The stop bit (without parity) is sampled at OVERSAMPLE/2 + 9·OVERSAMPLE ticks.
- Back-to-back frames: after the stop sample, the block is already in IDLE with half a stop bit remaining. A falling edge immediately after the stop bit is accepted, so it needs no idle gap.
- If `os_tick` is absent, all counters hold and the state does not advance. Only the IDLE edge detect works on `clk` alone.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state with even parity: the XOR of 8 data bits and the parity bit must be 0.
  - On a good stop bit, `parity_err` pulses together with `valid` when a mismatch occurred. `valid` still pulses.
  - On a framing error, `parity_err` stays 0.
  - The stop bit is sampled one bit period later.
- Undefined: no parity bit, `parity_err` is tied to 0, and the frame is 10 bits.

## Test plan
- Reset and idle, OVERSAMPLE=16:
  - During reset, all outputs are 0.
  - After release, with `rx`=1 for 1000 cycles: no pulses, `busy`=0.
- Frame 8'hA5 with a good stop bit:
  - `valid` is high for exactly one cycle and `data_out`=8'hA5.
  - `busy` spans start detection to the pulse.
  - Repeat with 8'h00 and 8'hFF back-to-back with no idle gap: two `valid` pulses, values are correct.
- Glitch: `rx` low for 4 os_ticks, then high → state returns to IDLE, no `valid`/`frame_err`, `data_out` unchanged.
- Stop bit 0 on data 8'h3C, then `rx` held low for 3 frame times:
  - `frame_err` pulses once, `data_out`=8'h3C, `valid`=0.
  - No further activity until `rx` rises and a new frame 8'h5A is received correctly.
- Reset asserted mid-DATA (after bit 3): outputs return to reset values at once, with no pulse. A subsequent frame 8'hC3 is received correctly.
- With `UART_RX_PARITY_EN`, send 8'h01:
  - Parity bit 1: `valid`=1, `parity_err`=0.
  - Parity bit 0: `valid`=1 and `parity_err`=1 in the same cycle.

Source files
------------

// File: rtl/receiver.sv
// receiver: UART 8-bit serial receiver, start/8 data LSB-first/stop, oversampled mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       os_tick_i,
  input  logic       rx_i,
  output logic [7:0] data_out_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int            CW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          mid_smp, full_smp, stop_smp, fall_edge;

  // Mid start bit is half a bit in; every later sample point is a full bit apart.
  assign mid_smp   = os_tick_i && (cnt_q == CNT_HALF);
  assign full_smp  = os_tick_i && (cnt_q == CNT_FULL);
  assign stop_smp  = (state_q == S_STOP) && full_smp;
  assign fall_edge = rx_prev_q && !rx_s_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall_edge) state_d = S_START;
      S_START: if (mid_smp) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (full_smp && idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (full_smp) state_d = S_STOP;
`endif
      S_STOP:  if (full_smp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change so each state measures from its own entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    else if (os_tick_i) cnt_d = (cnt_q == CNT_FULL) ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (state_q == S_START) idx_d = 3'd0;
    if (state_q == S_DATA && full_smp) begin
      shift_d[idx_q] = rx_s_q;
      idx_d          = idx_q + 3'd1;
    end
  end

  always_comb begin
    valid_d = stop_smp && rx_s_q;
    ferr_d  = stop_smp && !rx_s_q;
    data_d  = stop_smp ? shift_q : data_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;

  always_comb begin
    par_d = par_q;
    if (state_q == S_PARITY && full_smp) par_d = rx_s_q;
  end

  // Even parity: only reported alongside a good stop bit.
  always_comb begin
    perr_d = valid_d && (^{shift_q, par_q});
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign data_out_o  = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: randomized + directed frames against a frame-level expectation model.
module tb_receiver;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int STOP_TICKS = OS / 2 + (PAR_EN ? 10 : 9) * OS;

  logic       clk = 1'b0, rst_n = 1'b0, os_tick = 1'b0, rx = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, parity_err, busy;

  receiver #(.OVERSAMPLE(OS)) dut (
    .clk_i(clk), .rst_i(rst_n), .os_tick_i(os_tick), .rx_i(rx),
    .data_out_o(data_out), .valid_o(valid), .frame_err_o(frame_err),
    .parity_err_o(parity_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // os_tick: one clk wide, every third clk
  initial forever begin
    repeat (2) @(posedge clk);
    #1 os_tick = 1'b1;
    @(posedge clk);
    #1 os_tick = 1'b0;
  end

  int n_vec = 0, n_err = 0;
  int nv = 0, nf = 0, nboth = 0, nstray = 0, nlong = 0, nbusy = 0;
  logic [7:0] vdata = 8'h00, fdata = 8'h00;
  logic vperr = 1'b0, fperr = 1'b0, vbusy = 1'b0, prev_v = 1'b0, prev_f = 1'b0;

  always @(negedge clk) begin
    if (valid) begin nv <= nv + 1; vdata <= data_out; vperr <= parity_err; vbusy <= busy; end
    if (frame_err) begin nf <= nf + 1; fdata <= data_out; fperr <= parity_err; end
    if (valid && frame_err) nboth <= nboth + 1;
    if (parity_err && !valid) nstray <= nstray + 1;
    if ((valid && prev_v) || (frame_err && prev_f)) nlong <= nlong + 1;
    if (busy) nbusy <= nbusy + 1;
    prev_v <= valid;
    prev_f <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic p);
    return PAR_EN ? (^{d, p}) : 1'b0;
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    #1 rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(par_b);
    send_bit(stop_b);
  endtask

  // Expected outcome of one frame: good stop -> one valid with the byte,
  // bad stop -> one frame_err with the byte and no parity flag.
  task automatic frame_and_check(input string tag, input logic [7:0] d,
                                 input logic stop_b, input logic par_b);
    int v0, f0;
    v0 = nv;
    f0 = nf;
    send_frame(d, stop_b, par_b);
    check({tag, "_nvalid"}, nv - v0, stop_b ? 1 : 0);
    check({tag, "_nferr"}, nf - f0, stop_b ? 0 : 1);
    check({tag, "_busy_end"}, busy, 1'b0);
    if (stop_b) begin
      check({tag, "_data"}, vdata, d);
      check({tag, "_perr"}, vperr, exp_perr(d, par_b));
      check({tag, "_busy_at_pulse"}, vbusy, 1'b0);
    end else begin
      check({tag, "_ferr_data"}, fdata, d);
      check({tag, "_ferr_perr"}, fperr, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, v0, f0, span;
    logic [7:0] d;
    logic sb, pb;
    int gap;

    repeat (5) @(posedge clk);
    #2;
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    repeat (1000) @(posedge clk);
    #2;
    check("idle_nvalid", nv, 0);
    check("idle_nferr", nf, 0);
    check("idle_busy", nbusy, 0);

    b0 = nbusy;
    frame_and_check("a5", 8'hA5, 1'b1, ^8'hA5);
    span = nbusy - b0;
    check("a5_busy_span", (span >= 3 * STOP_TICKS - 6 && span <= 3 * STOP_TICKS + 3), 1'b1);

    frame_and_check("b2b_00", 8'h00, 1'b1, 1'b0);
    frame_and_check("b2b_ff", 8'hFF, 1'b1, 1'b0);

    // glitch: short low pulse must be rejected at mid start bit
    v0 = nv; f0 = nf; b0 = nbusy;
    #1 rx = 1'b0;
    wait_ticks(4);
    #1 rx = 1'b1;
    wait_ticks(2 * OS);
    check("glitch_seen", nbusy > b0, 1'b1);
    check("glitch_nvalid", nv - v0, 0);
    check("glitch_nferr", nf - f0, 0);
    check("glitch_busy", busy, 1'b0);
    check("glitch_data", data_out, 8'hFF);

    // bad stop then stuck-low line
    frame_and_check("ferr_3c", 8'h3C, 1'b0, ^8'h3C);
    v0 = nv; f0 = nf; b0 = nbusy;
    wait_ticks(3 * 10 * OS);
    check("stuck_nvalid", nv - v0, 0);
    check("stuck_nferr", nf - f0, 0);
    check("stuck_busy", nbusy - b0, 0);
    check("stuck_data", data_out, 8'h3C);
    send_bit(1'b1);
    frame_and_check("after_stuck_5a", 8'h5A, 1'b1, ^8'h5A);

    // reset mid-DATA after bit 3
    v0 = nv; f0 = nf;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_data", data_out, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", valid, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ticks(2 * OS);
    check("midrst_nvalid", nv - v0, 0);
    check("midrst_nferr", nf - f0, 0);
    frame_and_check("after_rst_c3", 8'hC3, 1'b1, ^8'hC3);

`ifdef UART_RX_PARITY_EN
    frame_and_check("par01_good", 8'h01, 1'b1, 1'b1);
    frame_and_check("par01_bad", 8'h01, 1'b1, 1'b0);
`endif

    for (int k = 0; k < 24; k++) begin
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 4) != 0);
      pb  = (^d) ^ ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 2);
      frame_and_check("rnd", d, sb, pb);
      if (!sb) send_bit(1'b1);
      if (gap != 0) wait_ticks(gap * OS / 2);
    end

    check("never_both", nboth, 0);
    check("no_stray_perr", nstray, 0);
    check("pulse_width", nlong, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
